// File: rtl/pc_fetch_stage.sv
// Instruction-fetch stage: owns the program counter, drives the instruction
// memory address, and registers the returned word into the IF/ID register.
// Redirects flush one bubble. Stalls freeze everything. A HALT opcode freezes
// fetch until a redirect or reset arrives.
module pc_fetch_stage #(
  parameter int unsigned               ADDR_WIDTH   = 8,
  parameter int unsigned               INSTR_WIDTH  = 32,
  parameter logic [ADDR_WIDTH-1:0]     RESET_VECTOR = 8'h00,
  parameter logic [5:0]                HALT_OPCODE  = 6'b111111,
  parameter logic [INSTR_WIDTH-1:0]    NOP_WORD     = 32'h00000000
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic                   Stall,
  input  logic                   Redirect,
  input  logic [ADDR_WIDTH-1:0]  RedirectTarget,
  output logic [ADDR_WIDTH-1:0]  Address,
  input  logic [INSTR_WIDTH-1:0] InstructionIn,
  output logic [INSTR_WIDTH-1:0] IFID_Instruction,
  output logic [ADDR_WIDTH-1:0]  IFID_PC,
  output logic [ADDR_WIDTH-1:0]  IFID_PCPlus1,
  output logic                   IFID_Valid,
  output logic                   Halted,
  output logic [15:0]            FetchCount
);

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] PC_STEP   = ADDR_WIDTH'(1);
  localparam logic [15:0]           COUNT_MAX = 16'hFFFF;

  state_t                   state, state_n;
  logic [ADDR_WIDTH-1:0]    pc, pc_n;
  logic [INSTR_WIDTH-1:0]   ifid_instr_n;
  logic [ADDR_WIDTH-1:0]    ifid_pc_n, ifid_pcplus1_n;
  logic                     ifid_valid_n;
  logic [15:0]              fetch_count_n;

  logic [ADDR_WIDTH-1:0]    pc_plus1;
  logic                     is_halt_word;

  // Carry out of the PC increment is dropped so fetch wraps at the top of IM.
  assign pc_plus1     = pc + PC_STEP;
  assign is_halt_word = (InstructionIn[INSTR_WIDTH-1 -: 6] == HALT_OPCODE);

  // The IM address is the PC itself, with no logic in between.
  assign Address = pc;
  assign Halted  = (state == ST_HALTED);

  // Next-state and next-datapath selection: Redirect > Stall > halt > fetch.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path can
    // leave one unassigned and infer a latch.
    state_n        = state;
    pc_n           = pc;
    ifid_instr_n   = IFID_Instruction;
    ifid_pc_n      = IFID_PC;
    ifid_pcplus1_n = IFID_PCPlus1;
    ifid_valid_n   = IFID_Valid;
    fetch_count_n  = FetchCount;

    if (Redirect) begin
      // The word currently at Address is squashed, even if it is a HALT.
      pc_n         = RedirectTarget;
      ifid_instr_n = NOP_WORD;
      ifid_valid_n = 1'b0;
      state_n      = ST_RUN;
    end else if (Stall) begin
      // Hold everything: the defaults already hold.
    end else if (state == ST_HALTED) begin
      // Keep feeding bubbles so the HALT word reaches decode only once.
      ifid_instr_n = NOP_WORD;
      ifid_valid_n = 1'b0;
    end else begin
      ifid_instr_n   = InstructionIn;
      ifid_pc_n      = pc;
      ifid_pcplus1_n = pc_plus1;
      ifid_valid_n   = 1'b1;
      if (FetchCount != COUNT_MAX) begin
        fetch_count_n = FetchCount + 16'd1;
      end
      if (is_halt_word) begin
        state_n = ST_HALTED;
      end else begin
        pc_n = pc_plus1;
      end
    end
  end

  // State, PC and IF/ID register update, with asynchronous clear.
  always_ff @(posedge Clk or posedge Reset) begin
    // NOTE: sequential state uses non-blocking assignments so all registers
    // update together from the values sampled at the same edge.
    if (Reset) begin
      state            <= ST_RUN;
      pc               <= RESET_VECTOR;
      IFID_Instruction <= NOP_WORD;
      IFID_PC          <= '0;
      IFID_PCPlus1     <= '0;
      IFID_Valid       <= 1'b0;
      FetchCount       <= '0;
    end else begin
      state            <= state_n;
      pc               <= pc_n;
      IFID_Instruction <= ifid_instr_n;
      IFID_PC          <= ifid_pc_n;
      IFID_PCPlus1     <= ifid_pcplus1_n;
      IFID_Valid       <= ifid_valid_n;
      FetchCount       <= fetch_count_n;
    end
  end

endmodule

// File: tb/tb_pc_fetch_stage.sv
// Directed bench for pc_fetch_stage with a combinational instruction-memory
// model. Expected values are hand-derived from the intended fetch behaviour.
module tb_pc_fetch_stage;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        redirect;
  logic [7:0]  redirect_target;
  logic [7:0]  address;
  logic [31:0] instruction_in;
  logic [31:0] ifid_instruction;
  logic [7:0]  ifid_pc;
  logic [7:0]  ifid_pcplus1;
  logic        ifid_valid;
  logic        halted;
  logic [15:0] fetch_count;

  logic [31:0] mem [256];

  int checks;
  int failures;

  pc_fetch_stage dut (
    .Clk              (clk),
    .Reset            (reset),
    .Stall            (stall),
    .Redirect         (redirect),
    .RedirectTarget   (redirect_target),
    .Address          (address),
    .InstructionIn    (instruction_in),
    .IFID_Instruction (ifid_instruction),
    .IFID_PC          (ifid_pc),
    .IFID_PCPlus1     (ifid_pcplus1),
    .IFID_Valid       (ifid_valid),
    .Halted           (halted),
    .FetchCount       (fetch_count)
  );

  // Instruction memory: same-cycle combinational read.
  assign instruction_in = mem[address];

  // 10-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Advance one rising edge and settle 1 unit past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    checks          = 0;
    failures        = 0;
    reset           = 1'b1;
    stall           = 1'b0;
    redirect        = 1'b0;
    redirect_target = 8'h00;
    for (int i = 0; i < 256; i++) mem[i] = {16'h00C0, 8'h00, i[7:0]};
    mem[0]  = 32'h11111111;
    mem[1]  = 32'h22222222;
    mem[2]  = 32'h33333333;
    mem[3]  = 32'h44444444;
    mem[24] = 32'hFC000000;
    mem[40] = 32'hFC000000;

    // Reset state.
    steps(2);
    check("rst_addr",   address,          32'h0);
    check("rst_instr",  ifid_instruction, 32'h0);
    check("rst_valid",  ifid_valid,       32'h0);
    check("rst_halted", halted,           32'h0);
    check("rst_count",  fetch_count,      32'h0);
    reset = 1'b0;

    // Reset and run: four edges.
    steps(4);
    check("run_addr",   address,          32'h4);
    check("run_instr",  ifid_instruction, 32'h44444444);
    check("run_pc",     ifid_pc,          32'h3);
    check("run_pcp1",   ifid_pcplus1,     32'h4);
    check("run_valid",  ifid_valid,       32'h1);
    check("run_count",  fetch_count,      32'h4);

    // Stall at PC=8 for two cycles.
    steps(4);
    check("pre_stall_addr", address, 32'h8);
    stall = 1'b1;
    steps(2);
    check("stall_addr",  address,          32'h8);
    check("stall_instr", ifid_instruction, 32'h00C00007);
    check("stall_pc",    ifid_pc,          32'h7);
    check("stall_valid", ifid_valid,       32'h1);
    check("stall_count", fetch_count,      32'h8);
    stall = 1'b0;
    step();
    check("unstall_instr", ifid_instruction, 32'h00C00008);
    check("unstall_addr",  address,          32'h9);

    // Redirect together with stall at PC=20.
    steps(11);
    check("pre_redir_addr", address, 32'd20);
    redirect        = 1'b1;
    redirect_target = 8'h2A;
    stall           = 1'b1;
    step();
    redirect = 1'b0;
    stall    = 1'b0;
    check("redir_addr",  address,          32'h2A);
    check("redir_valid", ifid_valid,       32'h0);
    check("redir_instr", ifid_instruction, 32'h0);
    check("redir_pc",    ifid_pc,          32'h13);
    check("redir_count", fetch_count,      32'd20);
    step();
    check("post_redir_instr", ifid_instruction, 32'h00C0002A);
    check("post_redir_pc",    ifid_pc,          32'h2A);
    check("post_redir_valid", ifid_valid,       32'h1);

    // Halt word at 24.
    redirect        = 1'b1;
    redirect_target = 8'd24;
    step();
    redirect = 1'b0;
    step();
    check("halt_instr",  ifid_instruction, 32'hFC000000);
    check("halt_valid",  ifid_valid,       32'h1);
    check("halt_addr",   address,          32'd24);
    check("halt_halted", halted,           32'h1);
    check("halt_count",  fetch_count,      32'd22);
    step();
    check("halted_valid", ifid_valid,       32'h0);
    check("halted_instr", ifid_instruction, 32'h0);
    steps(10);
    check("halted_addr",   address,     32'd24);
    check("halted_halted", halted,      32'h1);
    check("halted_count",  fetch_count, 32'd22);
    redirect        = 1'b1;
    redirect_target = 8'h05;
    step();
    check("unhalt_halted", halted,  32'h0);
    check("unhalt_addr",   address, 32'h5);

    // Squashed halt: redirect while the HALT word sits at Address.
    redirect_target = 8'd40;
    step();
    check("sq_pre_addr", address, 32'd40);
    redirect_target = 8'h60;
    step();
    redirect = 1'b0;
    check("sq_halted", halted,      32'h0);
    check("sq_valid",  ifid_valid,  32'h0);
    check("sq_addr",   address,     32'h60);
    check("sq_count",  fetch_count, 32'd22);

    // PC wrap.
    redirect        = 1'b1;
    redirect_target = 8'hFE;
    step();
    redirect = 1'b0;
    step();
    check("wrap1_addr", address, 32'hFF);
    step();
    check("wrap2_addr", address,      32'h00);
    check("wrap2_pc",   ifid_pc,      32'hFF);
    check("wrap2_pcp1", ifid_pcplus1, 32'h00);
    step();
    check("wrap3_addr",  address,     32'h01);
    check("wrap3_count", fetch_count, 32'd25);

    // FetchCount saturation over a long uninterrupted run.
    mem[24] = 32'h00C00018;
    mem[40] = 32'h00C00028;
    steps(65535 - 25);
    check("sat_reach", fetch_count, 32'hFFFF);
    steps(3);
    check("sat_stick", fetch_count, 32'hFFFF);
    check("sat_valid", ifid_valid,  32'h1);

    // Asynchronous reset mid-cycle, while halted.
    mem[address] = 32'hFC000000;
    step();
    check("pre_arst_halted", halted, 32'h1);
    #2;
    reset = 1'b1;
    #1;
    check("arst_addr",   address,          32'h0);
    check("arst_instr",  ifid_instruction, 32'h0);
    check("arst_pc",     ifid_pc,          32'h0);
    check("arst_pcp1",   ifid_pcplus1,     32'h0);
    check("arst_valid",  ifid_valid,       32'h0);
    check("arst_halted", halted,           32'h0);
    check("arst_count",  fetch_count,      32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
